mem_resp_demux: RTL and testbench

MEM_RESP_DEMUX -- requirements
Module: mem_resp_demux

---
 rtl/mem_resp_demux.sv | 148 ++++++++++++++
 tb/tb_mem_resp_demux.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_resp_demux.sv
// mem_resp_demux
//   Routes in-order responses from a shared memory port back to the
//   instruction or data requester. Every accepted request records a
//   {src, write} tag in a small FIFO; each memory response pops the head tag,
//   which decides where the response goes.
//
// Ports
//   clk, reset_n    : clock, synchronous active-low reset
//   req_fire        : memory port accepted a request this cycle
//   req_src         : 0 = instruction port, 1 = data port
//   req_write       : request was a write (response is an ack, no data)
//   req_ready       : tag FIFO has room (combinational from occupancy)
//   mem_resp_valid  : one memory response this cycle, in request order
//   mem_resp_data   : response data
//   i_resp_valid    : 1-cycle pulse, instruction read data valid
//   i_resp_data     : instruction read data, held until next i response
//   d_resp_valid    : 1-cycle pulse, data read data valid
//   d_resp_data     : data read data, held until next d read response
//   d_wack          : 1-cycle pulse, data write completed
//   outstanding     : tag FIFO occupancy, 0..DEPTH
//   err_underflow   : sticky, a response arrived with nothing outstanding
//
// Handshake: a push happens on a cycle where req_fire && req_ready; a pop
// happens on a cycle where mem_resp_valid && outstanding != 0. There is no
// backpressure on the response side; routed outputs appear one cycle later.
module mem_resp_demux #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_fire,
  input  logic             req_src,
  input  logic             req_write,
  output logic             req_ready,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_data,
  output logic             i_resp_valid,
  output logic [WIDTH-1:0] i_resp_data,
  output logic             d_resp_valid,
  output logic [WIDTH-1:0] d_resp_data,
  output logic             d_wack,
  output logic [CW-1:0]    outstanding,
  output logic             err_underflow
);

  // Tag layout: bit 1 = src, bit 0 = write.
  logic [1:0]       tag_mem_q [DEPTH];
  logic [1:0]       tag_mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             i_valid_q, i_valid_d;
  logic             d_valid_q, d_valid_d;
  logic             d_wack_q, d_wack_d;
  logic [WIDTH-1:0] i_data_q, i_data_d;
  logic [WIDTH-1:0] d_data_q, d_data_d;
  logic             err_q, err_d;

  logic       push;
  logic       pop;
  logic       underflow;
  logic [1:0] head_tag;

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never opens a slot for a push when the FIFO is full.
  assign req_ready = (count_q < CW'(DEPTH));
  assign push      = req_fire && req_ready;
  assign pop       = mem_resp_valid && (count_q != '0);
  assign underflow = mem_resp_valid && (count_q == '0);
  assign head_tag  = tag_mem_q[rd_ptr_q];

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    d_wack_d  = 1'b0;
    i_data_d  = i_data_q;
    d_data_d  = d_data_q;
    err_d     = err_q | underflow;

    if (push) begin
      tag_mem_d[wr_ptr_q] = {req_src, req_write};
      // DEPTH is a power of two, so natural overflow wraps modulo DEPTH.
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (!head_tag[1]) begin
        // Instruction side never issues meaningful writes; route regardless.
        i_valid_d = 1'b1;
        i_data_d  = mem_resp_data;
      end else if (!head_tag[0]) begin
        d_valid_d = 1'b1;
        d_data_d  = mem_resp_data;
      end else begin
        d_wack_d = 1'b1;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tag_mem_q[i] <= 2'b00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      d_wack_q  <= 1'b0;
      i_data_q  <= '0;
      d_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      tag_mem_q <= tag_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      d_wack_q  <= d_wack_d;
      i_data_q  <= i_data_d;
      d_data_q  <= d_data_d;
      err_q     <= err_d;
    end
  end

  assign i_resp_valid  = i_valid_q;
  assign i_resp_data   = i_data_q;
  assign d_resp_valid  = d_valid_q;
  assign d_resp_data   = d_data_q;
  assign d_wack        = d_wack_q;
  assign outstanding   = count_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_mem_resp_demux.sv
module tb_mem_resp_demux;
  localparam int W = 16;
  localparam int D = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_fire, req_src, req_write, req_ready;
  logic         mem_resp_valid;
  logic [W-1:0] mem_resp_data;
  logic         i_resp_valid, d_resp_valid, d_wack, err_underflow;
  logic [W-1:0] i_resp_data, d_resp_data;
  logic [2:0]   outstanding;

  always #5 clk = ~clk;

  mem_resp_demux #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_fire(req_fire), .req_src(req_src), .req_write(req_write),
    .req_ready(req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .d_wack(d_wack), .outstanding(outstanding),
    .err_underflow(err_underflow)
  );

  // ---------------- reference model + scoreboard ----------------
  // Model: a plain queue of outstanding {src, write} tags plus the values the
  // held data outputs and sticky error flag should show.
  logic [1:0]   m_tags[$];
  logic [W-1:0] m_i_data, m_d_data;
  logic         m_err;
  // Expected entry: {pulse vector {i,d,wack}, data expected on that port}.
  logic [W+2:0] exp_q[$];

  int  n_vec = 0;
  int  n_err = 0;
  bit  checking = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle of stimulus; the model predicts the effect of the edge.
  task automatic cyc(input logic f, input logic s, input logic w,
                     input logic rv, input logic [W-1:0] d);
    logic [1:0] t;
    bit         ready;
    req_fire = f; req_src = s; req_write = w;
    mem_resp_valid = rv; mem_resp_data = d;
    ready = (m_tags.size() < D);
    if (rv) begin
      if (m_tags.size() > 0) begin
        t = m_tags.pop_front();
        if (t[1] == 1'b0) begin
          m_i_data = d;
          exp_q.push_back({3'b100, d});
        end else if (t[0] == 1'b0) begin
          m_d_data = d;
          exp_q.push_back({3'b010, d});
        end else begin
          exp_q.push_back({3'b001, m_d_data});
        end
      end else begin
        m_err = 1'b1;
      end
    end
    if (f && ready) m_tags.push_back({s, w});
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Reset cycle with random noise on the inputs, which must be ignored.
  task automatic do_reset();
    reset_n = 1'b0;
    req_fire = 1'($urandom); req_src = 1'($urandom); req_write = 1'($urandom);
    mem_resp_valid = 1'($urandom); mem_resp_data = W'($urandom);
    m_tags.delete();
    m_i_data = '0; m_d_data = '0; m_err = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (checking) begin
      logic [2:0]   got;
      logic [W+2:0] e;
      got = {i_resp_valid, d_resp_valid, d_wack};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse", 32'(got), 32'(e[W+2:W]));
        if (e[W+2]) check("i_resp_data", 32'(i_resp_data), 32'(e[W-1:0]));
        else        check("d_resp_data", 32'(d_resp_data), 32'(e[W-1:0]));
      end else begin
        check("no_pulse", 32'(got), 32'd0);
      end
      check("i_data_hold", 32'(i_resp_data), 32'(m_i_data));
      check("d_data_hold", 32'(d_resp_data), 32'(m_d_data));
      check("outstanding", 32'(outstanding), 32'(m_tags.size()));
      check("req_ready", 32'(req_ready), 32'(m_tags.size() < D));
      check("err_underflow", 32'(err_underflow), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    req_fire = 1'b0; req_src = 1'b0; req_write = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    #1;
    checking = 1;
    do_reset();

    // Basic routing to the instruction port.
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 16'h1234);
    idle(2);

    // Ordering across all three destinations; wack keeps d data.
    cyc(1, 1, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    cyc(1, 1, 1, 0, '0);
    cyc(0, 0, 0, 1, 16'hAAAA);
    cyc(0, 0, 0, 1, 16'hBBBB);
    cyc(0, 0, 0, 1, 16'hCCCC);
    idle(2);

    // Fill, drop an extra push, then push+pop while full (push blocked),
    // push+pop while not full (count stable), refill and drain across wrap.
    for (int i = 0; i < D; i++) cyc(1, 1'($urandom), 1'($urandom), 0, '0);
    cyc(1, 0, 0, 0, '0);
    cyc(1, 1, 0, 1, 16'h0101);
    cyc(1, 0, 0, 1, 16'h0202);
    cyc(1, 1, 1, 0, '0);
    for (int i = 0; i < D; i++) cyc(0, 0, 0, 1, W'(16'h5000 + i));
    idle(2);

    // Underflow is sticky until reset.
    cyc(0, 0, 0, 1, 16'hDEAD);
    idle(3);
    do_reset();
    idle(2);

    // Underflow cycle with a simultaneous push still records the push.
    cyc(1, 1, 0, 1, 16'h7777);
    cyc(0, 0, 0, 1, 16'h8888);
    idle(1);

    // Reset mid-flight discards outstanding tags.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1'($urandom), 0, 0, '0);
    do_reset();
    cyc(0, 0, 0, 1, 16'hBEEF);
    idle(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      else cyc(1'($urandom_range(0, 99) < 55), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 99) < 50), W'($urandom));
    end
    idle(3);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
